// File: rtl/alu_test_pkg.sv
// Shared types and constants for the ALU self-test sweep sequencer.
package alu_test_pkg;

  localparam int NUM_VEC = 64;
  localparam int VEC_W   = 6;
  localparam int SIG_W   = 32;
  localparam int CNT_W   = 7;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] x);
    return {x[SIG_W-2:0], x[SIG_W-1]};
  endfunction

endpackage

// File: rtl/alu_sig_accum.sv
// Rotate-left-by-one / XOR signature register; clear takes priority over enable.
module alu_sig_accum
  import alu_test_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= rotl1(sig) ^ data;
    end
  end

endmodule

// File: rtl/alu_test_seq.sv
// Walks all 64 {ab_sel, alu_op} vectors through an external ALU and compacts
// the results into a signature plus zero/overflow flag hit counts.
//
// state   | meaning
// IDLE    | waiting for start; results of last sweep held
// APPLY   | vector on ab_sel/alu_op, ALU settling
// CAPTURE | fold alu_f into signature, count flags
// HOLD    | step mode pause after a capture, waits for step
// DONE    | one-cycle done pulse, back to IDLE
module alu_test_seq
  import alu_test_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic [2:0]       ab_sel,
  output logic [2:0]       alu_op,
  input  logic [SIG_W-1:0] alu_f,
  input  logic             alu_zf,
  input  logic             alu_of,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] zf_cnt,
  output logic [CNT_W-1:0] of_cnt
);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic             step_mode_q;
  logic             sig_clear;
  logic             sig_en;

  // alu_op is the fast field of the vector index
  assign ab_sel = vec[5:3];
  assign alu_op = vec[2:0];

  assign sig_clear = (state == ST_IDLE) && start;
  assign sig_en    = (state == ST_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      zf_cnt      <= '0;
      of_cnt      <= '0;
      step_mode_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= ST_APPLY;
            vec         <= '0;
            busy        <= 1'b1;
            zf_cnt      <= '0;
            of_cnt      <= '0;
            step_mode_q <= step_mode;
          end
        end
        ST_APPLY: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          zf_cnt <= zf_cnt + CNT_W'(alu_zf);
          of_cnt <= of_cnt + CNT_W'(alu_of);
          if (vec == LAST_VEC) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step_mode_q) begin
            state <= ST_HOLD;
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= ST_APPLY;
          end
        end
        ST_HOLD: begin
          // start is deliberately not looked at here: step wins
          if (step) begin
            vec   <= vec + VEC_W'(1);
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  alu_sig_accum u_sig_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sig_clear),
    .en    (sig_en),
    .data  (alu_f),
    .sig   (sig)
  );

endmodule

// File: tb/tb_alu_test_seq.sv
// Directed self-checking bench for alu_test_seq with a combinational ALU stub.
module tb_alu_test_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [2:0]  ab_sel;
  logic [2:0]  alu_op;
  logic [31:0] alu_f;
  logic        alu_zf;
  logic        alu_of;
  logic        busy;
  logic        done;
  logic [31:0] sig;
  logic [6:0]  zf_cnt;
  logic [6:0]  of_cnt;

  int checks   = 0;
  int failures = 0;

  logic       stub_var;
  logic [5:0] cur;

  // sweep observation results
  int          n_busy;
  int          n_done;
  int          done_cyc;
  int          n_vec;
  logic [5:0]  vec_seen [0:127];
  logic [31:0] sig_at32;

  alu_test_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .ab_sel    (ab_sel),
    .alu_op    (alu_op),
    .alu_f     (alu_f),
    .alu_zf    (alu_zf),
    .alu_of    (alu_of),
    .busy      (busy),
    .done      (done),
    .sig       (sig),
    .zf_cnt    (zf_cnt),
    .of_cnt    (of_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur = {ab_sel, alu_op};

  always_comb begin
    alu_f  = 32'h0000_0001;
    alu_zf = 1'b0;
    alu_of = 1'b1;
    if (stub_var) begin
      alu_f  = {26'd0, cur} * 32'h9E37_79B1;
      alu_zf = ((cur % 6'd5) == 6'd0);
      alu_of = cur[0] & cur[3];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sig"}, sig, 32'h0);
    check({tag, "_ctl"}, {17'd0, zf_cnt, of_cnt, busy, done, ab_sel, alu_op}, 32'h0);
  endtask

  // returns at the first negedge after the accepting posedge
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // observes a non-step sweep; call right after pulse_start
  task automatic run_sweep();
    logic [5:0] last;
    n_busy   = 0;
    n_done   = 0;
    done_cyc = 0;
    n_vec    = 0;
    sig_at32 = 32'hDEAD_BEEF;
    last     = 6'd0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (busy && (n_vec == 0 || cur != last)) begin
        if (n_vec < 128) vec_seen[n_vec] = cur;
        if (cur == 6'd32 && n_vec == 32) sig_at32 = sig;
        n_vec++;
        last = cur;
      end
      // start pulses mid-sweep and during DONE must be ignored
      start = (cyc == 50) || (done_cyc != 0 && cyc == done_cyc);
      if (done_cyc != 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  logic [31:0] exp_sig;
  int          exp_zf;
  int          exp_of;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    stub_var  = 1'b0;

    // reset and idle
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_reset_vals("idle_hold");
    end

    // constant stub sweep
    pulse_start();
    run_sweep();
    check("busy_cycles", 32'(n_busy), 32'd128);
    check("done_pulses", 32'(n_done), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'd129);
    check("vec_count", 32'(n_vec), 32'd64);
    for (int i = 0; i < 9; i++) check("vec_order", {26'd0, vec_seen[i]}, 32'(i));
    check("vec_last", {26'd0, vec_seen[63]}, 32'd63);
    check("sig_after31", sig_at32, 32'hFFFF_FFFF);
    check("sig_final", sig, 32'h0000_0000);
    check("of_cnt_final", {25'd0, of_cnt}, 32'd64);
    check("zf_cnt_final", {25'd0, zf_cnt}, 32'd0);
    repeat (5) @(negedge clk);
    check("idle_keeps", {sig[7:0], 3'd0, busy, 6'd0, of_cnt, zf_cnt}, {8'h00, 3'd0, 1'b0, 6'd0, 7'd64, 7'd0});

    // data-dependent stub sweep
    stub_var = 1'b1;
    exp_sig  = 32'h0;
    exp_zf   = 0;
    exp_of   = 0;
    for (int v = 0; v < 64; v++) begin
      exp_sig = {exp_sig[30:0], exp_sig[31]} ^ (32'(v) * 32'h9E37_79B1);
      if (v % 5 == 0) exp_zf++;
      if ((v & 9) == 9) exp_of++;
    end
    pulse_start();
    run_sweep();
    check("var_sig", sig, exp_sig);
    check("var_zf_cnt", {25'd0, zf_cnt}, 32'(exp_zf));
    check("var_of_cnt", {25'd0, of_cnt}, 32'(exp_of));
    check("var_done", 32'(n_done), 32'd1);
    stub_var = 1'b0;

    // step mode
    step_mode = 1'b1;
    pulse_start();
    step_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      check("hold_vec0", {25'd0, busy, cur}, {25'd0, 1'b1, 6'd0});
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_sig0", sig, 32'h1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_to_vec1", {26'd0, cur}, 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    check("step_outside_hold", {25'd0, busy, cur}, {25'd0, 1'b1, 6'd1});
    start = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    check("step_beats_start", {25'd0, busy, cur}, {25'd0, 1'b1, 6'd2});
    repeat (4) @(negedge clk);
    check("hold_vec2", {26'd0, cur}, 32'd2);
    check("step_sig3", sig, 32'h7);
    check("step_of_cnt", {25'd0, of_cnt}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset during vector 20
    pulse_start();
    begin
      int waited;
      waited = 0;
      while (!(busy && cur == 6'd20) && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("reach_vec20", {26'd0, cur}, 32'd20);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("no_done_after_reset", 32'(n_done), 32'd0);
    check("no_busy_after_reset", 32'(n_busy), 32'd0);
    pulse_start();
    run_sweep();
    check("restart_vec_count", 32'(n_vec), 32'd64);
    check("restart_busy", 32'(n_busy), 32'd128);
    check("restart_done", 32'(n_done), 32'd1);
    check("restart_sig", sig, 32'h0);
    check("restart_of_cnt", {25'd0, of_cnt}, 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
